timing_gen: RTL and testbench

TIMING_GEN -- requirements
Module: timing_gen

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/start_sync.sv | 58 +++++
 rtl/timing_gen.sv | 99 +++++++++
 tb/tb_timing_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared beat/phase/state types and decode helpers for timing_gen
//
// Purpose : common enums for the beat (W1..W3), the phase within a beat
//           (T1..T3) and the sequencer state (IDLE, RUN, HALT), plus the
//           beat-transition rule and one-hot decoders.
// Ports   : none (package).
package cpu_pkg;

    typedef enum logic [1:0] {
        W1 = 2'd0,
        W2 = 2'd1,
        W3 = 2'd2
    } beat_e;

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Beat that follows 'cur'. short only matters in W1 (and beats long
    // there), long only matters in W2, W3 always returns to W1.
    function automatic beat_e next_beat(input beat_e cur, input logic short_i,
                                        input logic long_i);
        beat_e nb;
        case (cur)
            W1:      nb = short_i ? W1 : W2;
            W2:      nb = long_i ? W3 : W1;
            default: nb = W1;
        endcase
        return nb;
    endfunction

    // One-hot as {w1, w2, w3}.
    function automatic logic [2:0] beat_onehot(input beat_e b);
        logic [2:0] v;
        case (b)
            W1:      v = 3'b100;
            W2:      v = 3'b010;
            W3:      v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // One-hot as {t1, t2, t3}.
    function automatic logic [2:0] phase_onehot(input phase_e p);
        logic [2:0] v;
        case (p)
            T1:      v = 3'b100;
            T2:      v = 3'b010;
            T3:      v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/start_sync.sv
// rtl/start_sync.sv - start button synchronizer with registered rising-edge pulse
//
// Purpose : brings the asynchronous start level into the clk domain through
//           two flops and emits a one-cycle registered pulse on each rising
//           edge of the synchronized level.
// Ports   : clk         - system clock
//           clr         - synchronous active-high reset
//           start       - raw asynchronous start level
//           start_pulse - one-cycle pulse per rising edge of start
module start_sync (
    input  logic clk,
    input  logic clr,
    input  logic start,
    output logic start_pulse
);
    import cpu_pkg::*;

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic       armed_q, armed_d;
    logic [1:0] fill_q,  fill_d;
    logic       pulse_q, pulse_d;

    // After clr the synchronizer holds reset zeros for two edges; fill_q marks
    // when sync2_q reflects a real sample. An edge is only accepted once a
    // genuine low level has been seen, so a button held through clr release
    // must be released and pressed again.
    always_comb begin
        sync1_d = start;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
        pulse_d = sync2_q & ~prev_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign start_pulse = pulse_q;

endmodule

// File: rtl/timing_gen.sv
// rtl/timing_gen.sv - beat/phase timing generator (W1..W3 beats of T1..T3 phases)
//
// Purpose : issues beats of three one-cycle phases; the next beat is chosen
//           from short/long at T3, stop at T3 parks the next beat as pending
//           and halts; a synchronized start edge resumes from idle/halt.
// Ports   : clk, clr (sync active-high reset), start (async level),
//           short, long, stop (controller hints, sampled at T3 only),
//           t1..t3 (phase one-hot), w1..w3 (beat one-hot), running.
module timing_gen (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic short,
    input  logic long,
    input  logic stop,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic w1,
    output logic w2,
    output logic w3,
    output logic running
);
    import cpu_pkg::*;

    logic start_pulse;

    start_sync u_start_sync (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .start_pulse (start_pulse)
    );

    state_e     state_q,   state_d;
    beat_e      beat_q,    beat_d;     // current beat in RUN, pending beat otherwise
    phase_e     phase_q,   phase_d;
    logic [2:0] t_q,       t_d;
    logic [2:0] w_q,       w_d;
    logic       running_q, running_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        phase_d = phase_q;
        case (state_q)
            RUN: begin
                // start_pulse is not looked at here: edges during RUN,
                // including one landing on a stopping T3, are dropped.
                case (phase_q)
                    T1:      phase_d = T2;
                    T2:      phase_d = T3;
                    default: begin
                        phase_d = T1;
                        beat_d  = next_beat(beat_q, short, long);
                        if (stop) begin
                            state_d = HALT;
                        end
                    end
                endcase
            end
            default: begin
                if (start_pulse) begin
                    state_d = RUN;
                    phase_d = T1;
                end
            end
        endcase

        // Outputs are registered from the next-state decode so they change
        // cleanly on the clock edge together with the state.
        running_d = (state_d == RUN);
        t_d       = running_d ? phase_onehot(phase_d) : 3'b000;
        w_d       = running_d ? beat_onehot(beat_d)   : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            beat_q    <= W1;
            phase_q   <= T1;
            t_q       <= 3'b000;
            w_q       <= 3'b000;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            phase_q   <= phase_d;
            t_q       <= t_d;
            w_q       <= w_d;
            running_q <= running_d;
        end
    end

    assign {t1, t2, t3} = t_q;
    assign {w1, w2, w3} = w_q;
    assign running      = running_q;

endmodule

// File: tb/tb_timing_gen.sv
// tb/tb_timing_gen.sv - directed self-checking bench for timing_gen
module tb_timing_gen;

    logic clk = 1'b0;
    logic clr, start, short, long, stop;
    logic t1, t2, t3, w1, w2, w3, running;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] WV1 = 3'b100;
    localparam logic [2:0] WV2 = 3'b010;
    localparam logic [2:0] WV3 = 3'b001;
    localparam logic [6:0] OFF = 7'b000_000_0;

    timing_gen dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .short   (short),
        .long    (long),
        .stop    (stop),
        .t1      (t1),
        .t2      (t2),
        .t3      (t3),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [6:0] exp, input string tag);
        logic [6:0] obs;
        obs = {t1, t2, t3, w1, w2, w3, running};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Start edge from IDLE/HALT: start first sampled at edge N; outputs stay
    // low after N+1 and N+2 and the beat appears after N+3 (on return).
    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick;
        tick;
        start = 1'b0;
        check(OFF, {tag, "_n1"});
        tick;
        check(OFF, {tag, "_n2"});
        tick;
    endtask

    // Called just after the edge that should start beat w. Checks T1..T3,
    // then drives s/l/st for the T3 sample. noise drives all controls high
    // during T1/T2 (must be ignored); go raises start at T3 and leaves it up.
    task automatic beat(input logic [2:0] w, input logic s, input logic l,
                        input logic st, input logic noise, input logic go,
                        input string tag);
        check({3'b100, w, 1'b1}, {tag, "_t1"});
        if (noise) {short, long, stop} = 3'b111;
        tick;
        check({3'b010, w, 1'b1}, {tag, "_t2"});
        tick;
        check({3'b001, w, 1'b1}, {tag, "_t3"});
        short = s;
        long  = l;
        stop  = st;
        if (go) start = 1'b1;
        tick;
        {short, long, stop} = 3'b000;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
        tick;
        tick;
        check(OFF, "reset");
        clr = 1'b0;
        tick; tick; tick;
        check(OFF, "idle");

        // Basic W1/W2 alternation, control noise outside T3, long, short priority
        pulse_start("go1");
        beat(WV1, 0, 0, 0, 0, 0, "a1");
        beat(WV2, 0, 0, 0, 0, 0, "a2");
        beat(WV1, 0, 0, 0, 1, 0, "a3");
        beat(WV2, 0, 1, 0, 0, 0, "a4");
        beat(WV3, 1, 1, 0, 0, 0, "a5");
        beat(WV1, 1, 1, 0, 0, 0, "a6");
        beat(WV1, 0, 1, 0, 0, 0, "a7");
        beat(WV2, 1, 0, 0, 0, 0, "a8");
        beat(WV1, 0, 0, 1, 0, 0, "a9");
        check(OFF, "halt1");
        tick;
        check(OFF, "halt1b");

        // Resume at pending W2, then long into W3 and stop there
        pulse_start("go2");
        beat(WV2, 0, 1, 0, 0, 0, "b1");
        beat(WV3, 0, 0, 1, 0, 0, "b2");
        check(OFF, "halt2");

        // Start held high through a whole run: exactly one resume
        start = 1'b1;
        tick;
        tick;
        check(OFF, "hold_n1");
        tick;
        check(OFF, "hold_n2");
        tick;
        beat(WV1, 0, 0, 0, 0, 0, "c1");
        beat(WV2, 0, 0, 0, 0, 0, "c2");
        beat(WV1, 0, 0, 0, 0, 0, "c3");
        beat(WV2, 0, 0, 1, 0, 0, "c4");
        check(OFF, "hold_halt");
        tick;
        check(OFF, "hold_halt_b");
        tick;
        check(OFF, "hold_halt_c");
        start = 1'b0;
        tick; tick; tick;
        check(OFF, "hold_rel");

        // Start edge arriving on the T3 that samples stop: halt wins
        pulse_start("go3");
        beat(WV1, 0, 0, 0, 0, 1, "d1");
        beat(WV2, 0, 1, 1, 0, 0, "d2");
        check(OFF, "race_halt");
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check(OFF, "race_idle");
        end

        // Resume at pending W3, then clr in the middle of W2 T2
        pulse_start("go4");
        beat(WV3, 0, 0, 0, 0, 0, "e1");
        beat(WV1, 0, 0, 0, 0, 0, "e2");
        check({3'b100, WV2, 1'b1}, "e3_t1");
        tick;
        check({3'b010, WV2, 1'b1}, "e3_t2");
        clr = 1'b1;
        tick;
        check(OFF, "clr_mid");
        clr = 1'b0;
        tick; tick; tick;
        check(OFF, "clr_idle");
        pulse_start("go5");
        beat(WV1, 0, 0, 0, 0, 0, "f1");

        // Start held through clr release produces no edge until re-pressed
        clr = 1'b1;
        start = 1'b1;
        tick;
        tick;
        check(OFF, "clr_hold");
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check(OFF, "clr_hold_noedge");
        end
        start = 1'b0;
        tick; tick; tick; tick;
        pulse_start("go6");
        beat(WV1, 0, 0, 0, 0, 0, "g1");
        check({3'b100, WV2, 1'b1}, "g2_t1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
